// File: rtl/ram_arbiter_pkg.sv
// Shared types and width helpers for the RAM arbiter and its picker.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_WAIT,
      ARB_DONE
   } arb_state_t;

   localparam int unsigned DEF_REQ_COUNT  = 3;
   localparam int unsigned DEF_ADDR_WIDTH = 23;
   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_TIMEOUT    = 255;

   // Index width for a set of n requesters (never below one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Watchdog width: must hold 0..t-1 (never below one bit).
   function automatic int unsigned wd_width(input int unsigned t);
      return (t < 2) ? 1 : $clog2(t);
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side bus of the arbiter; slave = arbiter view,
// master = view of the requesters plus the memory.
interface ram_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int unsigned REQ_COUNT  = DEF_REQ_COUNT,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
   localparam int unsigned IDX_W = idx_width(REQ_COUNT);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;

   // requester side
   logic [REQ_COUNT-1:0]                 req;
   logic [REQ_COUNT-1:0]                 req_we;
   logic [REQ_COUNT-1:0][ADDR_WIDTH-1:0] req_addr;
   logic [REQ_COUNT-1:0][DATA_WIDTH-1:0] req_wdata;
   logic [REQ_COUNT-1:0][BE_W-1:0]       req_be;
   logic [REQ_COUNT-1:0]                 ack;
   logic                                 err;
   logic [DATA_WIDTH-1:0]                rdata;

   // RAM side
   logic                                 ram_req;
   logic                                 ram_we;
   logic [ADDR_WIDTH-1:0]                ram_addr;
   logic [DATA_WIDTH-1:0]                ram_wdata;
   logic [BE_W-1:0]                      ram_be;
   logic                                 ram_ack;
   logic [DATA_WIDTH-1:0]                ram_rdata;

   // debug
   logic [IDX_W-1:0]                     grant_id;

   modport slave (
      input  req, req_we, req_addr, req_wdata, req_be, ram_ack, ram_rdata,
      output ack, err, rdata, ram_req, ram_we, ram_addr, ram_wdata, ram_be,
             grant_id
   );

   modport master (
      output req, req_we, req_addr, req_wdata, req_be, ram_ack, ram_rdata,
      input  ack, err, rdata, ram_req, ram_we, ram_addr, ram_wdata, ram_be,
             grant_id
   );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker with optional fixed priority for index 0.
// Scans upward from the pointer, wrapping at REQ_COUNT-1.
module rr_pick
   import ram_arb_pkg::*;
#(
   parameter  int unsigned REQ_COUNT = DEF_REQ_COUNT,
   localparam int unsigned IDX_W     = idx_width(REQ_COUNT)
) (
   input  logic [REQ_COUNT-1:0] req_i,
   input  logic [IDX_W-1:0]     ptr_i,
   input  logic                 prio0_i,
   output logic [IDX_W-1:0]     winner_o,
   output logic                 valid_o
);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REQ_COUNT - 1);

   logic [IDX_W-1:0] idx;

   // Pick the first set request at or after the pointer, or 0 under priority.
   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = ptr_i;
      if (prio0_i && req_i[0]) begin
         winner_o = '0;
         valid_o  = 1'b1;
      end else begin
         for (int unsigned k = 0; k < REQ_COUNT; k++) begin
            if (!valid_o && req_i[idx]) begin
               winner_o = idx;
               valid_o  = 1'b1;
            end
            idx = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between REQ_COUNT requesters: IDLE arbitrates and
// latches the winner's fields, WAIT holds ram_req until ram_ack or the
// watchdog fires, DONE pulses ack for one cycle and advances the pointer.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned REQ_COUNT  = DEF_REQ_COUNT,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter bit          PRIO0      = 1'b1,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input logic          CLK,
   input logic          RESET_n,
   ram_arbiter_if.slave arb_bus
);
   localparam int unsigned IDX_W = idx_width(REQ_COUNT);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned WD_W  = wd_width(TIMEOUT);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REQ_COUNT - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
   localparam bit               WD_EN    = (TIMEOUT != 0);

   arb_state_t            state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]       be_q, be_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_valid;

   rr_pick #(
      .REQ_COUNT(REQ_COUNT)
   ) u_pick (
      .req_i    (arb_bus.req),
      .ptr_i    (ptr_q),
      .prio0_i  (PRIO0),
      .winner_o (pick_idx),
      .valid_o  (pick_valid)
   );

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         wd_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         wd_q    <= wd_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state: arbitrate in IDLE, complete or time out in WAIT, rotate in DONE.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      wd_d    = wd_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = ARB_WAIT;
               grant_d = pick_idx;
               we_d    = arb_bus.req_we[pick_idx];
               addr_d  = arb_bus.req_addr[pick_idx];
               wdata_d = arb_bus.req_wdata[pick_idx];
               be_d    = arb_bus.req_be[pick_idx];
               wd_d    = '0;
            end
         end
         ARB_WAIT: begin
            // ram_ack is tested first so it beats a same-cycle timeout
            if (arb_bus.ram_ack) begin
               state_d = ARB_DONE;
               rdata_d = arb_bus.ram_rdata;
               err_d   = 1'b0;
            end else if (WD_EN && (wd_q == WD_LAST)) begin
               state_d = ARB_DONE;
               rdata_d = '0;
               err_d   = 1'b1;
            end else if (WD_EN) begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         ARB_DONE: begin
            state_d = ARB_IDLE;
            ptr_d   = (grant_q == IDX_LAST) ? '0 : grant_q + IDX_W'(1);
            wd_d    = '0;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Outputs: ram_req follows WAIT, ack pulses the winner during DONE.
   always_comb begin
      arb_bus.ram_req   = (state_q == ARB_WAIT);
      arb_bus.ram_we    = we_q;
      arb_bus.ram_addr  = addr_q;
      arb_bus.ram_wdata = wdata_q;
      arb_bus.ram_be    = be_q;
      arb_bus.ack       = '0;
      if (state_q == ARB_DONE) begin
         arb_bus.ack[grant_q] = 1'b1;
      end
      arb_bus.err      = err_q;
      arb_bus.rdata    = rdata_q;
      arb_bus.grant_id = grant_q;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: dut_rr is pure round-robin, dut_pr has requester-0 priority;
// both use a 4-cycle watchdog. Each side has a scripted memory responder.
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   localparam int unsigned RC = 3;
   localparam int unsigned AW = 23;
   localparam int unsigned DW = 16;

   logic CLK     = 1'b0;
   logic RESET_n = 1'b0;

   always #5 CLK = ~CLK;

   ram_arbiter_if #(.REQ_COUNT(RC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia ();
   ram_arbiter_if #(.REQ_COUNT(RC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib ();

   ram_arbiter #(.REQ_COUNT(RC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                 .PRIO0(1'b0), .TIMEOUT(4))
      dut_rr (.CLK(CLK), .RESET_n(RESET_n), .arb_bus(ia));

   ram_arbiter #(.REQ_COUNT(RC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                 .PRIO0(1'b1), .TIMEOUT(4))
      dut_pr (.CLK(CLK), .RESET_n(RESET_n), .arb_bus(ib));

   int n_cmp = 0;
   int n_bad = 0;

   // responder controls: delay = WAIT cycle number carrying ram_ack, 0 = never
   int unsigned a_delay = 1;
   int unsigned b_delay = 1;
   logic        a_force = 1'b0;
   logic [15:0] a_rd    = 16'h0;
   logic [15:0] b_rd    = 16'h0;

   initial begin
      int unsigned wcnt;
      wcnt = 0;
      ia.ram_ack   = 1'b0;
      ia.ram_rdata = '0;
      forever begin
         @(posedge CLK); #2;
         if (RESET_n && ia.ram_req) begin
            wcnt++;
            ia.ram_ack = a_force || ((a_delay != 0) && (wcnt == a_delay));
         end else begin
            wcnt = 0;
            ia.ram_ack = a_force;
         end
         ia.ram_rdata = a_rd;
      end
   end

   initial begin
      int unsigned wcnt;
      wcnt = 0;
      ib.ram_ack   = 1'b0;
      ib.ram_rdata = '0;
      forever begin
         @(posedge CLK); #2;
         if (RESET_n && ib.ram_req) begin
            wcnt++;
            ib.ram_ack = (b_delay != 0) && (wcnt == b_delay);
         end else begin
            wcnt = 0;
            ib.ram_ack = 1'b0;
         end
         ib.ram_rdata = b_rd;
      end
   end

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      RESET_n = 1'b0;
      repeat (2) step();
      n_cmp++; if (ia.ram_req !== 1'b0)   begin n_bad++; $display("FAIL reset_ram_req got %b want 0", ia.ram_req); end
      n_cmp++; if (ia.ack !== 3'b000)     begin n_bad++; $display("FAIL reset_ack got %b want 000", ia.ack); end
      n_cmp++; if (ia.err !== 1'b0)       begin n_bad++; $display("FAIL reset_err got %b want 0", ia.err); end
      n_cmp++; if (ia.rdata !== 16'h0)    begin n_bad++; $display("FAIL reset_rdata got %h want 0000", ia.rdata); end
      n_cmp++; if (ia.grant_id !== 2'd0)  begin n_bad++; $display("FAIL reset_grant got %0d want 0", ia.grant_id); end
      n_cmp++; if (ia.ram_addr !== 23'h0) begin n_bad++; $display("FAIL reset_ram_addr got %h want 0", ia.ram_addr); end
      n_cmp++; if (ia.ram_we !== 1'b0)    begin n_bad++; $display("FAIL reset_ram_we got %b want 0", ia.ram_we); end
      n_cmp++; if (ib.ram_req !== 1'b0)   begin n_bad++; $display("FAIL reset_pr_ram_req got %b want 0", ib.ram_req); end
      n_cmp++; if (ib.ack !== 3'b000)     begin n_bad++; $display("FAIL reset_pr_ack got %b want 000", ib.ack); end
      RESET_n = 1'b1;
      step();
   endtask

   task automatic test_prio();
      b_delay = 1;
      b_rd    = 16'h0B0B;
      ib.req_addr[0] = 23'h000010;
      ib.req_addr[2] = 23'h000012;
      ib.req = 3'b101;
      for (int c = 1; c <= 8; c++) begin
         logic [2:0] exp_ack;
         step();
         exp_ack = (c == 2 || c == 5) ? 3'b001 : (c == 8) ? 3'b100 : 3'b000;
         n_cmp++; if (ib.ack !== exp_ack) begin n_bad++; $display("FAIL prio_ack c=%0d got %b want %b", c, ib.ack, exp_ack); end
         if (c == 1 || c == 4) begin
            n_cmp++; if (ib.grant_id !== 2'd0) begin n_bad++; $display("FAIL prio_grant c=%0d got %0d want 0", c, ib.grant_id); end
         end
         if (c == 7) begin
            n_cmp++; if (ib.grant_id !== 2'd2) begin n_bad++; $display("FAIL prio_grant2 got %0d want 2", ib.grant_id); end
            n_cmp++; if (ib.ram_addr !== 23'h000012) begin n_bad++; $display("FAIL prio_addr2 got %h want 000012", ib.ram_addr); end
         end
         if (c == 5) ib.req[0] = 1'b0;
         if (c == 8) ib.req = '0;
      end
      step();
   endtask

   task automatic test_round_robin();
      a_delay = 1;
      a_rd    = 16'h1111;
      for (int i = 0; i < 3; i++) begin
         ia.req_addr[i]  = AW'(32'h100 + i);
         ia.req_we[i]    = (i == 1);
         ia.req_wdata[i] = DW'(32'hA000 + i);
         ia.req_be[i]    = 2'b11;
      end
      ia.req = 3'b111;
      for (int c = 1; c <= 18; c++) begin
         logic [2:0]  exp_ack;
         int unsigned g;
         step();
         g = (c / 3) % 3;
         exp_ack = (c % 3 == 2) ? (3'b001 << g) : 3'b000;
         n_cmp++; if (ia.ack !== exp_ack) begin n_bad++; $display("FAIL rr_ack c=%0d got %b want %b", c, ia.ack, exp_ack); end
         if (c % 3 == 1) begin
            n_cmp++; if (ia.grant_id !== 2'(g)) begin n_bad++; $display("FAIL rr_grant c=%0d got %0d want %0d", c, ia.grant_id, g); end
            n_cmp++; if (ia.ram_addr !== AW'(32'h100 + g)) begin n_bad++; $display("FAIL rr_addr c=%0d got %h want %h", c, ia.ram_addr, 32'h100 + g); end
            n_cmp++; if (ia.ram_we !== (g == 1)) begin n_bad++; $display("FAIL rr_we c=%0d got %b want %b", c, ia.ram_we, (g == 1)); end
         end
         if (c == 17) ia.req = '0;
      end
      step();
   endtask

   task automatic test_single_read();
      a_delay = 2;
      a_rd    = 16'hBEEF;
      ia.req_addr[1]  = 23'h000123;
      ia.req_we[1]    = 1'b0;
      ia.req_wdata[1] = 16'h0;
      ia.req_be[1]    = 2'b11;
      ia.req = 3'b010;
      for (int c = 1; c <= 4; c++) begin
         logic [2:0] exp_ack;
         step();
         exp_ack = (c == 3) ? 3'b010 : 3'b000;
         n_cmp++; if (ia.ack !== exp_ack) begin n_bad++; $display("FAIL rd_ack c=%0d got %b want %b", c, ia.ack, exp_ack); end
         n_cmp++; if (ia.ram_req !== (c <= 2)) begin n_bad++; $display("FAIL rd_ram_req c=%0d got %b want %b", c, ia.ram_req, (c <= 2)); end
         if (c == 1) begin
            n_cmp++; if (ia.ram_addr !== 23'h000123) begin n_bad++; $display("FAIL rd_addr got %h want 000123", ia.ram_addr); end
            n_cmp++; if (ia.ram_we !== 1'b0) begin n_bad++; $display("FAIL rd_we got %b want 0", ia.ram_we); end
            n_cmp++; if (ia.grant_id !== 2'd1) begin n_bad++; $display("FAIL rd_grant got %0d want 1", ia.grant_id); end
         end
         if (c == 3) begin
            n_cmp++; if (ia.rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rd_rdata got %h want beef", ia.rdata); end
            n_cmp++; if (ia.err !== 1'b0) begin n_bad++; $display("FAIL rd_err got %b want 0", ia.err); end
            ia.req = '0;
         end
      end
   endtask

   task automatic test_timeout();
      a_delay = 0;
      a_rd    = 16'h5A5A;
      ia.req_addr[2]  = 23'h7FFFFF;
      ia.req_we[2]    = 1'b1;
      ia.req_wdata[2] = 16'h1234;
      ia.req_be[2]    = 2'b01;
      ia.req = 3'b100;
      for (int c = 1; c <= 5; c++) begin
         logic [2:0] exp_ack;
         step();
         exp_ack = (c == 5) ? 3'b100 : 3'b000;
         n_cmp++; if (ia.ram_req !== (c <= 4)) begin n_bad++; $display("FAIL to_ram_req c=%0d got %b want %b", c, ia.ram_req, (c <= 4)); end
         n_cmp++; if (ia.ack !== exp_ack) begin n_bad++; $display("FAIL to_ack c=%0d got %b want %b", c, ia.ack, exp_ack); end
         if (c == 1) begin
            n_cmp++; if (ia.ram_we !== 1'b1) begin n_bad++; $display("FAIL to_we got %b want 1", ia.ram_we); end
            n_cmp++; if (ia.ram_wdata !== 16'h1234) begin n_bad++; $display("FAIL to_wdata got %h want 1234", ia.ram_wdata); end
            n_cmp++; if (ia.ram_be !== 2'b01) begin n_bad++; $display("FAIL to_be got %b want 01", ia.ram_be); end
            n_cmp++; if (ia.ram_addr !== 23'h7FFFFF) begin n_bad++; $display("FAIL to_addr got %h want 7fffff", ia.ram_addr); end
         end
         if (c == 5) begin
            n_cmp++; if (ia.err !== 1'b1) begin n_bad++; $display("FAIL to_err got %b want 1", ia.err); end
            n_cmp++; if (ia.rdata !== 16'h0) begin n_bad++; $display("FAIL to_rdata got %h want 0000", ia.rdata); end
            ia.req = '0;
         end
      end
      step();
      a_delay = 1;
      ia.req_addr[0] = 23'h000040;
      ia.req_we[0]   = 1'b0;
      ia.req = 3'b001;
      for (int c = 1; c <= 3; c++) begin
         logic [2:0] exp_ack;
         step();
         exp_ack = (c == 2) ? 3'b001 : 3'b000;
         n_cmp++; if (ia.ack !== exp_ack) begin n_bad++; $display("FAIL to_next_ack c=%0d got %b want %b", c, ia.ack, exp_ack); end
         if (c == 2) begin
            n_cmp++; if (ia.err !== 1'b0) begin n_bad++; $display("FAIL to_next_err got %b want 0", ia.err); end
            n_cmp++; if (ia.rdata !== 16'h5A5A) begin n_bad++; $display("FAIL to_next_rdata got %h want 5a5a", ia.rdata); end
            ia.req = '0;
         end
      end
   endtask

   task automatic test_simul_ack();
      a_delay = 4;
      a_rd    = 16'hC0DE;
      ia.req_addr[1] = 23'h000456;
      ia.req_we[1]   = 1'b0;
      ia.req = 3'b010;
      for (int c = 1; c <= 5; c++) begin
         logic [2:0] exp_ack;
         step();
         exp_ack = (c == 5) ? 3'b010 : 3'b000;
         n_cmp++; if (ia.ram_req !== (c <= 4)) begin n_bad++; $display("FAIL sim_ram_req c=%0d got %b want %b", c, ia.ram_req, (c <= 4)); end
         n_cmp++; if (ia.ack !== exp_ack) begin n_bad++; $display("FAIL sim_ack c=%0d got %b want %b", c, ia.ack, exp_ack); end
         if (c == 5) begin
            n_cmp++; if (ia.err !== 1'b0) begin n_bad++; $display("FAIL sim_err got %b want 0", ia.err); end
            n_cmp++; if (ia.rdata !== 16'hC0DE) begin n_bad++; $display("FAIL sim_rdata got %h want c0de", ia.rdata); end
            ia.req = '0;
         end
      end
      step();
   endtask

   task automatic test_reset_mid_wait();
      a_delay = 0;
      a_rd    = 16'h7777;
      ia.req_addr[1] = 23'h000111;
      ia.req_addr[2] = 23'h000222;
      ia.req_we[1]   = 1'b0;
      ia.req_we[2]   = 1'b0;
      ia.req = 3'b110;
      step();
      n_cmp++; if (ia.grant_id !== 2'd2) begin n_bad++; $display("FAIL rst_pre_grant got %0d want 2", ia.grant_id); end
      n_cmp++; if (ia.ram_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_ram_req got %b want 1", ia.ram_req); end
      RESET_n = 1'b0;
      #1;
      n_cmp++; if (ia.ram_req !== 1'b0) begin n_bad++; $display("FAIL rst_async_ram_req got %b want 0", ia.ram_req); end
      n_cmp++; if (ia.grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_async_grant got %0d want 0", ia.grant_id); end
      step();
      n_cmp++; if (ia.ack !== 3'b000) begin n_bad++; $display("FAIL rst_ack got %b want 000", ia.ack); end
      a_delay = 1;
      RESET_n = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         logic [2:0] exp_ack;
         step();
         exp_ack = (c == 2) ? 3'b010 : 3'b000;
         n_cmp++; if (ia.ack !== exp_ack) begin n_bad++; $display("FAIL rst_post_ack c=%0d got %b want %b", c, ia.ack, exp_ack); end
         if (c == 1) begin
            n_cmp++; if (ia.grant_id !== 2'd1) begin n_bad++; $display("FAIL rst_post_grant got %0d want 1", ia.grant_id); end
            n_cmp++; if (ia.ram_addr !== 23'h000111) begin n_bad++; $display("FAIL rst_post_addr got %h want 000111", ia.ram_addr); end
         end
         if (c == 2) ia.req = '0;
      end
   endtask

   task automatic test_stray_ack();
      a_force = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         step();
         n_cmp++; if (ia.ram_req !== 1'b0) begin n_bad++; $display("FAIL stray_ram_req c=%0d got %b want 0", c, ia.ram_req); end
         n_cmp++; if (ia.ack !== 3'b000) begin n_bad++; $display("FAIL stray_ack c=%0d got %b want 000", c, ia.ack); end
      end
      a_force = 1'b0;
      step();
   endtask

   task automatic test_drop_mid_wait();
      a_delay = 2;
      a_rd    = 16'h3333;
      ia.req_addr[2]  = 23'h000333;
      ia.req_wdata[2] = 16'hABCD;
      ia.req_we[2]    = 1'b1;
      ia.req = 3'b100;
      for (int c = 1; c <= 4; c++) begin
         logic [2:0] exp_ack;
         step();
         exp_ack = (c == 3) ? 3'b100 : 3'b000;
         n_cmp++; if (ia.ack !== exp_ack) begin n_bad++; $display("FAIL drop_ack c=%0d got %b want %b", c, ia.ack, exp_ack); end
         if (c == 1) begin
            ia.req = '0;
            ia.req_addr[2]  = 23'h000777;
            ia.req_wdata[2] = 16'h0000;
            ia.req_we[2]    = 1'b0;
         end
         if (c == 2) begin
            n_cmp++; if (ia.ram_req !== 1'b1) begin n_bad++; $display("FAIL drop_ram_req got %b want 1", ia.ram_req); end
            n_cmp++; if (ia.ram_addr !== 23'h000333) begin n_bad++; $display("FAIL drop_addr got %h want 000333", ia.ram_addr); end
            n_cmp++; if (ia.ram_wdata !== 16'hABCD) begin n_bad++; $display("FAIL drop_wdata got %h want abcd", ia.ram_wdata); end
            n_cmp++; if (ia.ram_we !== 1'b1) begin n_bad++; $display("FAIL drop_we got %b want 1", ia.ram_we); end
         end
         if (c == 4) begin
            n_cmp++; if (ia.ram_req !== 1'b0) begin n_bad++; $display("FAIL drop_idle_ram_req got %b want 0", ia.ram_req); end
         end
      end
   endtask

   initial begin
      ia.req = '0; ia.req_we = '0; ia.req_addr = '0; ia.req_wdata = '0; ia.req_be = '0;
      ib.req = '0; ib.req_we = '0; ib.req_addr = '0; ib.req_wdata = '0; ib.req_be = '0;
      test_reset();
      test_prio();
      test_round_robin();
      test_single_read();
      test_timeout();
      test_simul_ack();
      test_reset_mid_wait();
      test_stray_ack();
      test_drop_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one SDRAM-side RAM port between REQ_COUNT requesters, e.g. the boot/flash loader, the mapper/CPU path and the TF DMA.
- Sits between the requester blocks and the SDRAM (or UMA primary) port, all in the 108 MHz CLK domain.
- Fixed-priority override for requester 0, round-robin among the rest.
- A watchdog terminates transactions the memory never acknowledges.

Parameters:
- REQ_COUNT, 3: number of requesters (2..8).
- ADDR_WIDTH, 23: word address width.
- DATA_WIDTH, 16: data width.
- PRIO0, 1: 1 = requester 0 always wins when requesting; 0 = pure round-robin.
- TIMEOUT, 255: cycles in WAIT before forced completion; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock (108 MHz).
- RESET_n  in  1  asynchronous, active-low reset.
- req  in  [REQ_COUNT]  per-requester request level.
- req_we  in  [REQ_COUNT]  1 = write.
- req_addr  in  [REQ_COUNT][ADDR_WIDTH]  address.
- req_wdata  in  [REQ_COUNT][DATA_WIDTH]  write data.
- req_be  in  [REQ_COUNT][DATA_WIDTH/8]  byte enables.
- ack  out  [REQ_COUNT]  one-cycle completion pulse.
- err  out  1  valid with ack: transaction timed out.
- rdata  out  DATA_WIDTH  read data, valid with ack.
- ram_req  out  1  downstream request level.
- ram_we  out  1  downstream write.
- ram_addr  out  ADDR_WIDTH  downstream address.
- ram_wdata  out  DATA_WIDTH  downstream write data.
- ram_be  out  DATA_WIDTH/8  downstream byte enables.
- ram_ack  in  1  downstream one-cycle completion.
- ram_rdata  in  DATA_WIDTH  valid with ram_ack.
- grant_id  out  $clog2(REQ_COUNT)  current or last winner (debug/LED).

Behaviour:
- Clock and reset: one clock, CLK. Reset RESET_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; watchdog 0.
- State IDLE: if any req is set, pick a winner and latch its we/addr/wdata/be into registers. Next cycle is WAIT with ram_req=1 and grant_id=winner.
- Winner selection: if PRIO0 and req[0], winner=0. Otherwise the first set req at or after the pointer, scanning upward and wrapping modulo REQ_COUNT. Requester 0 takes part in the round-robin when PRIO0=0.
- State WAIT: ram_req held at 1; ram_* outputs stable from the latched registers; watchdog increments each cycle.
  - On ram_ack: capture ram_rdata into rdata, err=0, ram_req=0, go to DONE.
  - If TIMEOUT!=0 and watchdog==TIMEOUT-1 without ram_ack: ram_req=0, rdata=0, err=1, go to DONE.
  - ram_ack and timeout in the same cycle: ram_ack wins, err=0.
- State DONE (exactly one cycle):
  - ack[winner]=1, and err/rdata are valid in this cycle.
  - Pointer becomes winner+1 modulo REQ_COUNT, also when the winner was requester 0 under PRIO0.
  - Watchdog cleared. Return to IDLE; no arbitration is done in DONE.
- Requester rule: hold req and the fields stable until ack is seen; drop req at or before the edge after ack. Holding req high issues a new transaction after IDLE.
- Latency: request to ack is at least 3 cycles (IDLE sample, WAIT with same-cycle ram_ack, DONE). Back-to-back grants are spaced at least 3 cycles apart.
- Boundaries:
  - A req that drops during WAIT does not abort the transaction; ack still pulses.
  - A req that changes fields mid-transaction has no effect, because the fields are latched.
  - A ram_ack arriving in IDLE or DONE is ignored.
  - Under PRIO0, requesters 1..N-1 can starve while requester 0 is continuously active; this is by design.
  - RESET_n asserted mid-WAIT aborts immediately: no ack is issued and ram_req drops asynchronously.
- Widths: pointer and grant_id are $clog2(REQ_COUNT) bits, and wrap uses an explicit compare against REQ_COUNT-1, not bit overflow.

Decomposition:
- Package ram_arb_pkg holds:
  - typedef enum {ARB_IDLE, ARB_WAIT, ARB_DONE} arb_state_t;
  - the function clog2-based width constants.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the req vector, the pointer and prio0. Outputs are winner index and valid. It is reusable by UMA.

Test Plan:
- Single read: req[1]=1, addr=0x000123, memory acks 2 cycles after ram_req with 0xBEEF -> ram_addr=0x000123 and ram_we=0; ack[1] pulses once with rdata=0xBEEF and err=0; total 4 cycles.
- All three requesting continuously, PRIO0=0, ram_ack on the first WAIT cycle -> grants 0,1,2,0,1,2; each ack 3 cycles apart.
- PRIO0=1: req[0] held and req[2] held -> only 0 granted; after req[0] drops following its ack, 2 is granted next.
- Timeout: TIMEOUT=4, no ram_ack -> ram_req high exactly 4 cycles; ack with err=1 and rdata=0; a later transaction completes normally with err=0.
- Simultaneous ram_ack on the final watchdog cycle -> err=0 and rdata=ram_rdata.
- RESET_n low for 1 cycle mid-WAIT -> ram_req=0 immediately, no ack; after release a pending req is granted with the pointer at 0.
